// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencer: detects load-use hazards between ID and EX, selects EX operand
//   sources (regfile / WB forward / PC / immediate), stalls IF/ID, inserts bubbles and
//   flushes after redirects, and freezes the pipe while data memory is busy.
//   Keeps a free-running count of cycles with stall_if asserted.
// Parameters
//   LD_STALL_CYCLES  bubbles inserted on a load-use hazard (1..7)
//   FLUSH_CYCLES     cycles flush_id/flush_ex are held after a redirect (1..7)
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_*   source registers and operand usage of the ID instruction
//   ex_rd/ex_regwen/ex_is_load destination info of the EX instruction
//   wb_rd/wb_regwen           destination info of the WB instruction
//   redirect                  taken branch / jump resolved in EX
//   mem_busy                  memory not ready, whole pipe freezes
//   stall_if/stall_id         hold PC / hold IF/ID register
//   flush_id/flush_ex         NOP into IF/ID / bubble into ID/EX
//   fwd_a_sel/fwd_b_sel       operand mux selects (00 regfile, 01 WB, 10 PC/IMM)
//   stall_count               stall_if cycles since reset, wraps
module hazard_controller #(
   parameter int unsigned LD_STALL_CYCLES = 1,
   parameter int unsigned FLUSH_CYCLES    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic        id_use_pc,
   input  logic        id_use_imm,
   input  logic [4:0]  ex_rd,
   input  logic        ex_regwen,
   input  logic        ex_is_load,
   input  logic [4:0]  wb_rd,
   input  logic        wb_regwen,
   input  logic        redirect,
   input  logic        mem_busy,
   output logic        stall_if,
   output logic        stall_id,
   output logic        flush_id,
   output logic        flush_ex,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic [31:0] stall_count
);

   typedef enum logic [1:0] {StRun, StLdStall, StFlush, StMemWait} state_e;

   // Reload values are "remaining cycles after the current one".
   localparam logic [2:0] LdReload = 3'(LD_STALL_CYCLES - 1);
   localparam logic [2:0] FlReload = 3'(FLUSH_CYCLES - 1);
   localparam bit         LdMulti  = (LD_STALL_CYCLES > 1);
   localparam bit         FlMulti  = (FLUSH_CYCLES > 1);

   state_e      state_q, state_d, ret_q, ret_d, eff_state;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] stall_count_q, stall_count_d;
   logic        hz_ld;

   assign hz_ld = ex_is_load & ex_regwen & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   // Forwarding is purely combinational and independent of the FSM.
   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (id_use_pc) begin
         fwd_a_sel = 2'b10;
      end else if (id_use_rs1 & wb_regwen & (wb_rd != 5'd0) & (wb_rd == id_rs1)) begin
         fwd_a_sel = 2'b01;
      end
      if (id_use_imm) begin
         fwd_b_sel = 2'b10;
      end else if (id_use_rs2 & wb_regwen & (wb_rd != 5'd0) & (wb_rd == id_rs2)) begin
         fwd_b_sel = 2'b01;
      end
   end

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      cnt_d    = cnt_q;
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;

      // Once memory is ready again, MEM_WAIT behaves exactly like the state it froze.
      eff_state = (state_q == StMemWait) ? ret_q : state_q;

      if (mem_busy) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         state_d  = StMemWait;
         ret_d    = eff_state;
      end else if (redirect) begin
         // A redirect flushes from any state and restarts the flush window.
         flush_id = 1'b1;
         flush_ex = 1'b1;
         cnt_d    = FlReload;
         state_d  = FlMulti ? StFlush : StRun;
      end else begin
         state_d = eff_state;
         unique case (eff_state)
            StLdStall: begin
               stall_if = 1'b1;
               stall_id = 1'b1;
               flush_ex = 1'b1;
               cnt_d    = cnt_q - 3'd1;
               if (cnt_q <= 3'd1) begin
                  cnt_d   = 3'd0;
                  state_d = StRun;
               end
            end
            StFlush: begin
               flush_id = 1'b1;
               flush_ex = 1'b1;
               cnt_d    = cnt_q - 3'd1;
               if (cnt_q <= 3'd1) begin
                  cnt_d   = 3'd0;
                  state_d = StRun;
               end
            end
            default: begin
               state_d = StRun;
               if (hz_ld) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  flush_ex = 1'b1;
                  cnt_d    = LdReload;
                  state_d  = LdMulti ? StLdStall : StRun;
               end
            end
         endcase
      end

      if (rst) begin
         stall_if = 1'b0;
         stall_id = 1'b0;
         flush_id = 1'b0;
         flush_ex = 1'b0;
      end

      stall_count_d = stall_count_q + {31'd0, stall_if};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         ret_q         <= StRun;
         cnt_q         <= 3'd0;
         stall_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         ret_q         <= ret_d;
         cnt_q         <= cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two instances (LD=1/FL=2 and LD=3/FL=1) share inputs and
// are compared each cycle against a remaining-cycles reference model, plus directed checks.
module tb_hazard_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd, wb_rd;
   logic       id_use_rs1, id_use_rs2, id_use_pc, id_use_imm;
   logic       ex_regwen, ex_is_load, wb_regwen, redirect, mem_busy;

   logic        stall_if [2];
   logic        stall_id [2];
   logic        flush_id [2];
   logic        flush_ex [2];
   logic [1:0]  fwd_a_sel [2];
   logic [1:0]  fwd_b_sel [2];
   logic [31:0] stall_count [2];

   hazard_controller #(.LD_STALL_CYCLES(1), .FLUSH_CYCLES(2)) u_dut_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .ex_rd(ex_rd),
      .ex_regwen(ex_regwen), .ex_is_load(ex_is_load), .wb_rd(wb_rd), .wb_regwen(wb_regwen),
      .redirect(redirect), .mem_busy(mem_busy), .stall_if(stall_if[0]), .stall_id(stall_id[0]),
      .flush_id(flush_id[0]), .flush_ex(flush_ex[0]), .fwd_a_sel(fwd_a_sel[0]),
      .fwd_b_sel(fwd_b_sel[0]), .stall_count(stall_count[0])
   );

   hazard_controller #(.LD_STALL_CYCLES(3), .FLUSH_CYCLES(1)) u_dut_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .ex_rd(ex_rd),
      .ex_regwen(ex_regwen), .ex_is_load(ex_is_load), .wb_rd(wb_rd), .wb_regwen(wb_regwen),
      .redirect(redirect), .mem_busy(mem_busy), .stall_if(stall_if[1]), .stall_id(stall_id[1]),
      .flush_id(flush_id[1]), .flush_ex(flush_ex[1]), .fwd_a_sel(fwd_a_sel[1]),
      .fwd_b_sel(fwd_b_sel[1]), .stall_count(stall_count[1])
   );

   int checks = 0;
   int errors = 0;

   int ldp [2] = '{1, 3};
   int flp [2] = '{2, 1};

   // Reference model: remaining bubble / flush cycles owed after the current cycle.
   int          ld_left [2];
   int          fl_left [2];
   int          nx_ld [2];
   int          nx_fl [2];
   logic        e_si [2];
   logic [31:0] cnt_m [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] fwd_exp(input logic alt, input logic use_r, input logic [4:0] rs);
      if (alt) return 2'b10;
      if (use_r && wb_regwen && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic sample();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         logic hz, si, fid, fex;
         int   nl, nf;
         hz = ex_is_load && ex_regwen && ex_rd != 5'd0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
         si = 1'b0; fid = 1'b0; fex = 1'b0;
         nl = ld_left[k]; nf = fl_left[k];
         if (rst) begin
            nl = 0; nf = 0;
         end else if (mem_busy) begin
            si = 1'b1;
         end else if (redirect) begin
            fid = 1'b1; fex = 1'b1; nf = flp[k] - 1; nl = 0;
         end else if (fl_left[k] > 0) begin
            fid = 1'b1; fex = 1'b1; nf = fl_left[k] - 1;
         end else if (ld_left[k] > 0) begin
            si = 1'b1; fex = 1'b1; nl = ld_left[k] - 1;
         end else if (hz) begin
            si = 1'b1; fex = 1'b1; nl = ldp[k] - 1;
         end
         chk($sformatf("stall_if[%0d]", k), 32'(stall_if[k]), 32'(si));
         chk($sformatf("stall_id[%0d]", k), 32'(stall_id[k]), 32'(si));
         chk($sformatf("flush_id[%0d]", k), 32'(flush_id[k]), 32'(fid));
         chk($sformatf("flush_ex[%0d]", k), 32'(flush_ex[k]), 32'(fex));
         chk($sformatf("fwd_a[%0d]", k), 32'(fwd_a_sel[k]),
             32'(fwd_exp(id_use_pc, id_use_rs1, id_rs1)));
         chk($sformatf("fwd_b[%0d]", k), 32'(fwd_b_sel[k]),
             32'(fwd_exp(id_use_imm, id_use_rs2, id_rs2)));
         chk($sformatf("stall_count[%0d]", k), stall_count[k], cnt_m[k]);
         nx_ld[k] = nl;
         nx_fl[k] = nf;
         e_si[k]  = si;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         ld_left[k] = nx_ld[k];
         fl_left[k] = nx_fl[k];
         cnt_m[k]   = rst ? 32'd0 : cnt_m[k] + (e_si[k] ? 32'd1 : 32'd0);
      end
      #1;
   endtask

   task automatic clear();
      rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; wb_rd = '0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_use_pc = 1'b0; id_use_imm = 1'b0;
      ex_regwen = 1'b0; ex_is_load = 1'b0; wb_regwen = 1'b0; redirect = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic do_reset();
      clear();
      rst = 1'b1;
      sample();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] r);
      ex_is_load = 1'b1; ex_regwen = 1'b1; ex_rd = r; id_rs1 = r; id_use_rs1 = 1'b1;
   endtask

   initial begin
      clear();
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         ld_left[k] = 0; fl_left[k] = 0; nx_ld[k] = 0; nx_fl[k] = 0;
         e_si[k] = 1'b0; cnt_m[k] = 32'd0;
      end
      @(posedge clk);
      #1;
      do_reset();
      chk("reset_count_a", stall_count[0], 32'd0);

      // Load-use with a single bubble.
      set_load_use(5'd5);
      sample();
      chk("t1_stall", 32'(stall_if[0]), 32'd1);
      chk("t1_bubble", 32'(flush_ex[0]), 32'd1);
      tick();
      clear();
      sample();
      chk("t1_stall_once", 32'(stall_if[0]), 32'd0);
      chk("t1_count", stall_count[0], 32'd1);
      tick();

      // x0 never stalls nor forwards.
      do_reset();
      set_load_use(5'd0);
      wb_rd = 5'd0; wb_regwen = 1'b1;
      sample();
      chk("t2_no_stall", 32'(stall_if[0]), 32'd0);
      chk("t2_fwd_x0", 32'(fwd_a_sel[0]), 32'd0);
      tick();

      // WB forward on B, then immediate wins.
      clear();
      wb_rd = 5'd7; wb_regwen = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
      sample();
      chk("t3_fwd_wb", 32'(fwd_b_sel[0]), 32'd1);
      tick();
      id_use_imm = 1'b1;
      sample();
      chk("t3_fwd_imm", 32'(fwd_b_sel[0]), 32'd2);
      tick();

      // Redirect beats load-use; two flush cycles, no stall.
      do_reset();
      set_load_use(5'd5);
      redirect = 1'b1;
      sample();
      chk("t4_flush0", 32'(flush_id[0]), 32'd1);
      chk("t4_nostall0", 32'(stall_if[0]), 32'd0);
      tick();
      clear();
      sample();
      chk("t4_flush1", 32'(flush_ex[0]), 32'd1);
      chk("t4_nostall1", 32'(stall_if[0]), 32'd0);
      tick();
      sample();
      chk("t4_flush_done", 32'(flush_id[0]), 32'd0);
      tick();

      // Load-use (3 bubbles on instance b) frozen by 4 busy cycles.
      do_reset();
      set_load_use(5'd9);
      sample();
      tick();
      clear();
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sample();
         chk("t5_freeze_stall", 32'(stall_if[1]), 32'd1);
         chk("t5_freeze_noflush", 32'(flush_ex[1]), 32'd0);
         tick();
      end
      mem_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample();
         chk("t5_resume", 32'(flush_ex[1]), 32'd1);
         tick();
      end
      sample();
      chk("t5_done", 32'(stall_if[1]), 32'd0);
      chk("t5_count", stall_count[1], 32'd7);
      tick();

      // Reset in the middle of a flush window.
      do_reset();
      redirect = 1'b1;
      sample();
      tick();
      redirect = 1'b0;
      rst = 1'b1;
      sample();
      tick();
      rst = 1'b0;
      sample();
      chk("t6_flush", 32'(flush_id[0]), 32'd0);
      chk("t6_stall", 32'(stall_if[0]), 32'd0);
      chk("t6_count", stall_count[0], 32'd0);
      tick();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 49) == 0);
         mem_busy   = ($urandom_range(0, 5) == 0);
         redirect   = ($urandom_range(0, 7) == 0);
         ex_is_load = ($urandom_range(0, 1) == 0);
         ex_regwen  = ($urandom_range(0, 3) != 0);
         wb_regwen  = ($urandom_range(0, 1) == 0);
         id_use_rs1 = ($urandom_range(0, 1) == 0);
         id_use_rs2 = ($urandom_range(0, 1) == 0);
         id_use_pc  = ($urandom_range(0, 4) == 0);
         id_use_imm = ($urandom_range(0, 2) == 0);
         id_rs1     = 5'($urandom_range(0, 3));
         id_rs2     = 5'($urandom_range(0, 3));
         ex_rd      = 5'($urandom_range(0, 3));
         wb_rd      = 5'($urandom_range(0, 3));
         sample();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
